miniproc_sequencer: RTL

Multi-cycle instruction sequencer for the MiniProc datapath. It fetches 32-bit R-type instruction words from an external program ROM, decodes them, and drives the 32x32 register file and the ALU through read, execute and write-back phases. It replaces hand-driven control-unit stimulus with autonomous program execution. Handshake is START/BUSY/DONE.

---
 rtl/miniproc_sequencer_pkg.sv | 52 +++++
 rtl/miniproc_sequencer_if.sv | 47 ++++
 rtl/miniproc_sequencer_decoder.sv | 31 +++
 rtl/miniproc_sequencer.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/miniproc_sequencer_pkg.sv
// Shared definitions for the MiniProc sequencer: instruction field layout,
// funct/opcode codes, FSM state encoding and a funct legality helper.
package miniproc_sequencer_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int INSTR_WIDTH        = 32;
  localparam int REG_ADDR_WIDTH     = 5;
  localparam int OPCODE_WIDTH       = 6;
  localparam int FUNCT_WIDTH        = 6;
  localparam int SHAMT_WIDTH        = 5;

  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;

  localparam logic [OPCODE_WIDTH-1:0] OPCODE_RTYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OPCODE_HALT  = 6'h3F;

  localparam logic [FUNCT_WIDTH-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_MUL = 6'h2C;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLL = 6'h01;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SRL = 6'h02;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_NOR = 6'h27;
  localparam logic [FUNCT_WIDTH-1:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_FINISH,
    S_ERROR
  } seq_state_t;

  function automatic logic is_legal_funct(input logic [FUNCT_WIDTH-1:0] funct);
    case (funct)
      FUNCT_ADD, FUNCT_SUB, FUNCT_MUL, FUNCT_SLL, FUNCT_SRL,
      FUNCT_AND, FUNCT_OR, FUNCT_NOR, FUNCT_SLT: is_legal_funct = 1'b1;
      default:                                   is_legal_funct = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/miniproc_sequencer_if.sv
// Bus bundle between the sequencer and its ROM, register file and ALU.
interface miniproc_sequencer_if
  import miniproc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  // Handshake: start is a one-cycle pulse honoured only while the sequencer is
  // idle (busy low, done low); busy rises on the cycle after acceptance and stays
  // high through the single done cycle. rf_data_r1/r2 follow rf_addr_r1/r2 and are
  // sampled at the end of the cycle rf_read is high; rf_addr_w/rf_data_w are valid
  // whenever rf_write is high; alu_result is combinational from alu_op1/op2/code.
  logic                      start;
  logic [ADDR_WIDTH-1:0]     prog_len;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic [ADDR_WIDTH-1:0]     instr_count;
  logic [ADDR_WIDTH-1:0]     instr_addr;
  logic [INSTR_WIDTH-1:0]    instr_data;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r1;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r2;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_w;
  logic                      rf_read;
  logic                      rf_write;
  logic [DATA_WIDTH-1:0]     rf_data_r1;
  logic [DATA_WIDTH-1:0]     rf_data_r2;
  logic [DATA_WIDTH-1:0]     rf_data_w;
  logic [DATA_WIDTH-1:0]     alu_op1;
  logic [DATA_WIDTH-1:0]     alu_op2;
  logic [FUNCT_WIDTH-1:0]    alu_code;
  logic [DATA_WIDTH-1:0]     alu_result;

  modport master (
    input  start, prog_len, instr_data, rf_data_r1, rf_data_r2, alu_result,
    output busy, done, err, instr_count, instr_addr, rf_addr_r1, rf_addr_r2,
           rf_addr_w, rf_read, rf_write, rf_data_w, alu_op1, alu_op2, alu_code
  );

  modport slave (
    output start, prog_len, instr_data, rf_data_r1, rf_data_r2, alu_result,
    input  busy, done, err, instr_count, instr_addr, rf_addr_r1, rf_addr_r2,
           rf_addr_w, rf_read, rf_write, rf_data_w, alu_op1, alu_op2, alu_code
  );

endinterface

// File: rtl/miniproc_sequencer_decoder.sv
// Combinational instruction decoder: splits the instruction register into
// fields and classifies it as legal R-type, HALT or illegal.
module miniproc_sequencer_decoder
  import miniproc_sequencer_pkg::*;
(
  input  logic [INSTR_WIDTH-1:0]    ir,
  output logic [REG_ADDR_WIDTH-1:0] rs,
  output logic [REG_ADDR_WIDTH-1:0] rt,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [SHAMT_WIDTH-1:0]    shamt,
  output logic [FUNCT_WIDTH-1:0]    funct,
  output logic                      is_legal,
  output logic                      is_halt,
  output logic                      use_shamt
);

  logic [OPCODE_WIDTH-1:0] opcode;

  assign opcode = ir[OPCODE_LSB +: OPCODE_WIDTH];
  assign rs     = ir[RS_LSB +: REG_ADDR_WIDTH];
  assign rt     = ir[RT_LSB +: REG_ADDR_WIDTH];
  assign rd     = ir[RD_LSB +: REG_ADDR_WIDTH];
  assign shamt  = ir[SHAMT_LSB +: SHAMT_WIDTH];
  assign funct  = ir[FUNCT_LSB +: FUNCT_WIDTH];

  assign is_halt   = (opcode == OPCODE_HALT);
  assign is_legal  = (opcode == OPCODE_RTYPE) && is_legal_funct(funct);
  // Shifts take their second operand from the shamt field instead of rt.
  assign use_shamt = (funct == FUNCT_SLL) || (funct == FUNCT_SRL);

endmodule

// File: rtl/miniproc_sequencer.sv
// Multi-cycle sequencer: fetch, decode, register read, execute and write-back
// of R-type programs from an external ROM; five cycles per retired instruction.
module miniproc_sequencer
  import miniproc_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  miniproc_sequencer_if.master bus,
  output seq_state_t          dbg_state
);

  seq_state_t                state;
  logic [ADDR_WIDTH-1:0]     pc;
  logic [ADDR_WIDTH-1:0]     pc_inc;
  logic [ADDR_WIDTH-1:0]     prog_len_q;
  logic [ADDR_WIDTH-1:0]     instr_count_q;
  logic [INSTR_WIDTH-1:0]    ir;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r1_q;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_r2_q;
  logic [REG_ADDR_WIDTH-1:0] rf_addr_w_q;
  logic [DATA_WIDTH-1:0]     alu_op1_q;
  logic [DATA_WIDTH-1:0]     alu_op2_q;
  logic [DATA_WIDTH-1:0]     result_q;
  logic [FUNCT_WIDTH-1:0]    alu_code_q;
  logic                      rf_read_q;
  logic                      rf_write_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;

  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
  logic [SHAMT_WIDTH-1:0]    shamt;
  logic [FUNCT_WIDTH-1:0]    funct;
  logic                      is_legal, is_halt, use_shamt;

  miniproc_sequencer_decoder u_decoder (
    .ir        (ir),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .is_legal  (is_legal),
    .is_halt   (is_halt),
    .use_shamt (use_shamt)
  );

  assign pc_inc = pc + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pc            <= '0;
      prog_len_q    <= '0;
      instr_count_q <= '0;
      ir            <= '0;
      rf_addr_r1_q  <= '0;
      rf_addr_r2_q  <= '0;
      rf_addr_w_q   <= '0;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_code_q    <= '0;
      result_q      <= '0;
      rf_read_q     <= 1'b0;
      rf_write_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rf_read_q  <= 1'b0;
      rf_write_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pc            <= '0;
            instr_count_q <= '0;
            err_q         <= 1'b0;
            busy_q        <= 1'b1;
            prog_len_q    <= bus.prog_len;
            if (bus.prog_len == '0) begin
              done_q <= 1'b1;
              state  <= S_FINISH;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          ir    <= bus.instr_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (is_halt) begin
            done_q <= 1'b1;
            state  <= S_FINISH;
          end else if (!is_legal) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= S_ERROR;
          end else begin
            rf_addr_r1_q <= rs;
            rf_addr_r2_q <= rt;
            rf_read_q    <= 1'b1;
            state        <= S_READ;
          end
        end
        S_READ: begin
          alu_op1_q  <= bus.rf_data_r1;
          alu_op2_q  <= use_shamt ? DATA_WIDTH'(shamt) : bus.rf_data_r2;
          alu_code_q <= funct;
          state      <= S_EXEC;
        end
        S_EXEC: begin
          // r0 is hardwired: the instruction retires but the write is suppressed.
          result_q    <= bus.alu_result;
          rf_addr_w_q <= rd;
          rf_write_q  <= (rd != '0);
          state       <= S_WRITE;
        end
        S_WRITE: begin
          pc            <= pc_inc;
          instr_count_q <= instr_count_q + ADDR_WIDTH'(1);
          if (pc_inc == prog_len_q) begin
            done_q <= 1'b1;
            state  <= S_FINISH;
          end else begin
            state <= S_FETCH;
          end
        end
        S_FINISH, S_ERROR: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.instr_count = instr_count_q;
  assign bus.instr_addr  = pc;
  assign bus.rf_addr_r1  = rf_addr_r1_q;
  assign bus.rf_addr_r2  = rf_addr_r2_q;
  assign bus.rf_addr_w   = rf_addr_w_q;
  assign bus.rf_read     = rf_read_q;
  assign bus.rf_write    = rf_write_q;
  assign bus.rf_data_w   = result_q;
  assign bus.alu_op1     = alu_op1_q;
  assign bus.alu_op2     = alu_op2_q;
  assign bus.alu_code    = alu_code_q;
  assign dbg_state       = state;

endmodule
